// File: rtl/irq_pkg.sv
// irq_pkg
// Shared definitions for the interrupt controller: register offsets
// (decoded from byte address bits [3:2]), interrupt ID width and the
// reserved "no interrupt" ID.
package irq_pkg;

  // Interrupt IDs are 5 bits wide: 0 means "none", 1..31 map to sources 0..30.
  localparam int IRQ_ID_W   = 5;
  localparam int IRQ_ID_MAX = 31;

  localparam logic [IRQ_ID_W-1:0] IRQ_ID_NONE = '0;

  // Register map, word offsets within the controller's address window.
  typedef enum logic [1:0] {
    IRQ_REG_PENDING = 2'b00,
    IRQ_REG_ENABLE  = 2'b01,
    IRQ_REG_CLAIM   = 2'b10,
    IRQ_REG_CTRL    = 2'b11
  } irq_reg_e;

endpackage

// File: rtl/irq_gateway.sv
// irq_gateway
// Per-source interrupt state: a sticky pending flag and an in-service flag.
// A source only latches a new request while it is neither pending nor being
// serviced, so a level held high through its ISR re-pends only after the
// matching complete.
//   clk        system clock
//   rst        synchronous active-high reset
//   src        level interrupt input, high = request
//   claim      this source won a claim read this cycle
//   complete   core wrote this source's ID to CLAIM this cycle
//   pending    request latched, waiting to be claimed
//   in_service request claimed, waiting for completion
module irq_gateway
  import irq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);

  // Claim moves the request from pending into service; complete ends the
  // service period. A claim and a complete never target the same source in
  // one cycle because the bus accepts one request per ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      if (claim) begin
        pending <= 1'b0;
      end else if (src && !in_service && !pending) begin
        pending <= 1'b1;
      end

      if (claim) begin
        in_service <= 1'b1;
      end else if (complete) begin
        in_service <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl
// Level-sensitive interrupt controller with claim/complete register
// interface on a Wishbone-style slave bus. Fixed priority: lowest source
// index wins. Source k is reported as ID k+1; ID 0 means none.
//   i_CLK, i_RST          clock, synchronous active-high reset
//   i_ADDR/i_DATA/i_WE    bus address (only [3:2] decoded), write data, write
//   i_SEL, i_TAGN         ignored
//   i_STB/i_CYC           strobe and cycle; o_ACK single-cycle acknowledge
//   o_DATA                read data while o_ACK is high, otherwise 0
//   o_TAGN                tied 0
//   i_SRC                 level interrupt sources
//   o_IRQ                 registered request: GIE & any pending+enabled
//   o_IRQ_ID              registered winner ID, independent of GIE
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_SRC      = 8
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [ADDR_WIDTH-1:0] i_ADDR,
  input  logic [DATA_WIDTH-1:0] i_DATA,
  output logic [DATA_WIDTH-1:0] o_DATA,
  input  logic                  i_WE,
  input  logic [3:0]            i_SEL,
  input  logic                  i_STB,
  output logic                  o_ACK,
  input  logic                  i_CYC,
  input  logic                  i_TAGN,
  output logic                  o_TAGN,
  input  logic [N_SRC-1:0]      i_SRC,
  output logic                  o_IRQ,
  output logic [IRQ_ID_W-1:0]   o_IRQ_ID
);

  logic [N_SRC-1:0]      pending;
  logic [N_SRC-1:0]      in_service;
  logic [N_SRC-1:0]      enable;
  logic [N_SRC-1:0]      active;
  logic [N_SRC-1:0]      claim_vec;
  logic [N_SRC-1:0]      complete_vec;
  logic                  gie;
  logic                  valid_req;
  logic                  rd_claim;
  logic                  wr_complete;
  logic                  cmp_ok;
  logic [IRQ_ID_W-1:0]   cmp_id;
  logic [IRQ_ID_W-1:0]   win_id;
  logic [IRQ_ID_W-1:0]   isr_cnt;
  logic [DATA_WIDTH-1:0] rd_data;
  irq_reg_e              reg_sel;
  logic                  unused_bits;

  assign unused_bits = &{1'b0, i_SEL, i_TAGN, i_ADDR[ADDR_WIDTH-1:4], i_ADDR[1:0]};
  assign o_TAGN      = 1'b0;

  assign reg_sel   = irq_reg_e'(i_ADDR[3:2]);
  // Masking the request with o_ACK forces an idle cycle after every ack.
  assign valid_req = i_CYC && i_STB && !o_ACK;
  assign active    = pending & enable;

  // Complete IDs are checked against the full data word so that stray upper
  // bits never alias onto a real source.
  assign cmp_ok      = (i_DATA != '0) && (i_DATA <= DATA_WIDTH'(N_SRC));
  assign cmp_id      = i_DATA[IRQ_ID_W-1:0];
  assign rd_claim    = valid_req && !i_WE && (reg_sel == IRQ_REG_CLAIM);
  assign wr_complete = valid_req && i_WE && (reg_sel == IRQ_REG_CLAIM) && cmp_ok;

  // Priority encoder: scanning downwards leaves the lowest active index.
  always_comb begin
    win_id = IRQ_ID_NONE;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (active[k]) win_id = IRQ_ID_W'(k + 1);
    end
  end

  // Claim/complete strobes to the gateways. The claim targets the winner of
  // the pre-edge pending set, so a source latching on the same edge cannot
  // steal it.
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int k = 0; k < N_SRC; k++) begin
      claim_vec[k]    = rd_claim && (win_id == IRQ_ID_W'(k + 1));
      complete_vec[k] = wr_complete && (cmp_id == IRQ_ID_W'(k + 1));
    end
  end

  // Number of sources currently in service, saturated to the field width.
  always_comb begin
    int cnt;
    cnt = 0;
    for (int k = 0; k < N_SRC; k++) begin
      if (in_service[k]) cnt++;
    end
    isr_cnt = (cnt > IRQ_ID_MAX) ? IRQ_ID_W'(IRQ_ID_MAX) : IRQ_ID_W'(cnt);
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      IRQ_REG_PENDING: rd_data[N_SRC-1:0]    = pending;
      IRQ_REG_ENABLE:  rd_data[N_SRC-1:0]    = enable;
      IRQ_REG_CLAIM:   rd_data[IRQ_ID_W-1:0] = win_id;
      IRQ_REG_CTRL: begin
        rd_data[0]    = gie;
        rd_data[12:8] = isr_cnt;
      end
      default: rd_data = '0;
    endcase
  end

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    irq_gateway u_gateway (
      .clk        (i_CLK),
      .rst        (i_RST),
      .src        (i_SRC[k]),
      .claim      (claim_vec[k]),
      .complete   (complete_vec[k]),
      .pending    (pending[k]),
      .in_service (in_service[k])
    );
  end

  // Bus response, writable registers and the registered request outputs.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      enable   <= '0;
      gie      <= 1'b0;
      o_ACK    <= 1'b0;
      o_DATA   <= '0;
      o_IRQ    <= 1'b0;
      o_IRQ_ID <= IRQ_ID_NONE;
    end else begin
      o_ACK  <= valid_req;
      o_DATA <= (valid_req && !i_WE) ? rd_data : '0;
      if (valid_req && i_WE) begin
        if (reg_sel == IRQ_REG_ENABLE) enable <= i_DATA[N_SRC-1:0];
        if (reg_sel == IRQ_REG_CTRL)   gie    <= i_DATA[0];
      end
      o_IRQ    <= gie && (|active);
      o_IRQ_ID <= win_id;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl
// Self-checking bench for irq_ctrl: directed sequences for reset, timing and
// simultaneous-event corners, a table of register transactions for priority,
// masking and bad completes, then randomized traffic checked against a
// behavioural model of the controller's rules.
module tb_irq_ctrl;
  import irq_pkg::*;

  localparam int N = 8;

  logic        i_CLK;
  logic        i_RST;
  logic [31:0] i_ADDR;
  logic [31:0] i_DATA;
  logic [31:0] o_DATA;
  logic        i_WE;
  logic [3:0]  i_SEL;
  logic        i_STB;
  logic        o_ACK;
  logic        i_CYC;
  logic        i_TAGN;
  logic        o_TAGN;
  logic [N-1:0] i_SRC;
  logic        o_IRQ;
  logic [4:0]  o_IRQ_ID;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          wr;
    irq_reg_e    addr;
    logic [31:0] wdata;
    logic [7:0]  src;
    logic [31:0] exp_rd;
    bit          exp_irq;
    logic [4:0]  exp_id;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: per-source flags as plain arrays plus mask and GIE.
  bit         m_pend[N];
  bit         m_isvc[N];
  logic [7:0] m_en;
  bit         m_gie;

  irq_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .N_SRC(N)) dut (
    .i_CLK    (i_CLK),
    .i_RST    (i_RST),
    .i_ADDR   (i_ADDR),
    .i_DATA   (i_DATA),
    .o_DATA   (o_DATA),
    .i_WE     (i_WE),
    .i_SEL    (i_SEL),
    .i_STB    (i_STB),
    .o_ACK    (o_ACK),
    .i_CYC    (i_CYC),
    .i_TAGN   (i_TAGN),
    .o_TAGN   (o_TAGN),
    .i_SRC    (i_SRC),
    .o_IRQ    (o_IRQ),
    .o_IRQ_ID (o_IRQ_ID)
  );

  // Free-running 100 MHz clock.
  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  // Guard against a stuck run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus transaction; also checks the ack is exactly one cycle long and
  // that read data returns to zero once the ack drops.
  task automatic busAccess(input bit wr, input irq_reg_e addr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
    @(negedge i_CLK);
    i_CYC  = 1'b1;
    i_STB  = 1'b1;
    i_WE   = wr;
    i_ADDR = {28'h0, addr, 2'b00};
    i_DATA = wdata;
    @(posedge i_CLK);
    #1;
    checkOutput("ack_high", {31'b0, o_ACK}, 32'h1);
    rdata = o_DATA;
    i_CYC = 1'b0;
    i_STB = 1'b0;
    i_WE  = 1'b0;
    @(posedge i_CLK);
    #1;
    checkOutput("ack_low", {31'b0, o_ACK}, 32'h0);
    checkOutput("data_idle", o_DATA, 32'h0);
  endtask

  // Hold the row's sources long enough to latch, run its transaction, let
  // any re-pend and the registered outputs settle, then check them.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] rd;
    i_SRC = v.src;
    repeat (3) @(posedge i_CLK);
    #1;
    busAccess(v.wr, v.addr, v.wdata, rd);
    if (!v.wr) checkOutput($sformatf("vec%0d_rd", idx), rd, v.exp_rd);
    repeat (2) @(posedge i_CLK);
    #1;
    checkOutput($sformatf("vec%0d_irq", idx), {31'b0, o_IRQ}, {31'b0, v.exp_irq});
    checkOutput($sformatf("vec%0d_id", idx), {27'b0, o_IRQ_ID}, {27'b0, v.exp_id});
  endtask

  function automatic vec_t mk(input bit wr, input irq_reg_e addr, input logic [31:0] wdata,
                              input logic [7:0] src, input logic [31:0] exp_rd,
                              input bit exp_irq, input logic [4:0] exp_id);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.src = src;
    v.exp_rd = exp_rd; v.exp_irq = exp_irq; v.exp_id = exp_id;
    return v;
  endfunction

  function automatic int mWinner();
    for (int k = 0; k < N; k++) begin
      if (m_pend[k] && m_en[k]) return k + 1;
    end
    return 0;
  endfunction

  function automatic void mSettle(input logic [7:0] s);
    for (int k = 0; k < N; k++) begin
      if (s[k] && !m_isvc[k]) m_pend[k] = 1'b1;
    end
  endfunction

  function automatic void mReset();
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 1'b0;
      m_isvc[k] = 1'b0;
    end
    m_en  = '0;
    m_gie = 1'b0;
  endfunction

  function automatic logic [31:0] mRead(input irq_reg_e addr);
    logic [31:0] r;
    int cnt;
    r = '0;
    cnt = 0;
    for (int k = 0; k < N; k++) begin
      if (addr == IRQ_REG_PENDING && m_pend[k]) r = r | (32'h1 << k);
      if (m_isvc[k]) cnt++;
    end
    if (addr == IRQ_REG_ENABLE) r = {24'h0, m_en};
    if (addr == IRQ_REG_CTRL)   r = (32'(cnt) << 8) | {31'h0, m_gie};
    return r;
  endfunction

  // Main test sequence.
  initial begin
    logic [31:0] rd;
    logic [7:0]  src;
    logic [31:0] d;
    int          op;
    int          exp_id;

    i_RST = 1'b1; i_ADDR = '0; i_DATA = '0; i_WE = 1'b0; i_SEL = 4'hF;
    i_STB = 1'b0; i_CYC = 1'b0; i_TAGN = 1'b0; i_SRC = '0;

    // Reset and idle.
    repeat (3) @(posedge i_CLK);
    #1;
    checkOutput("rst_irq", {31'b0, o_IRQ}, 32'h0);
    checkOutput("rst_id", {27'b0, o_IRQ_ID}, 32'h0);
    checkOutput("rst_ack", {31'b0, o_ACK}, 32'h0);
    checkOutput("rst_data", o_DATA, 32'h0);
    checkOutput("rst_tagn", {31'b0, o_TAGN}, 32'h0);
    @(negedge i_CLK);
    i_RST = 1'b0;
    busAccess(1'b0, IRQ_REG_PENDING, 32'h0, rd); checkOutput("rst_pending", rd, 32'h0);
    busAccess(1'b0, IRQ_REG_ENABLE, 32'h0, rd);  checkOutput("rst_enable", rd, 32'h0);
    busAccess(1'b0, IRQ_REG_CTRL, 32'h0, rd);    checkOutput("rst_ctrl", rd, 32'h0);

    // Basic flow with a one-cycle source pulse and the two-cycle latency.
    busAccess(1'b1, IRQ_REG_CTRL, 32'h1, rd);
    busAccess(1'b1, IRQ_REG_ENABLE, 32'h1, rd);
    @(negedge i_CLK);
    i_SRC = 8'h01;
    @(posedge i_CLK);
    #1;
    checkOutput("lat_edge_t", {31'b0, o_IRQ}, 32'h0);
    i_SRC = 8'h00;
    @(posedge i_CLK);
    #1;
    checkOutput("lat_edge_t1", {31'b0, o_IRQ}, 32'h1);
    checkOutput("lat_id", {27'b0, o_IRQ_ID}, 32'h1);
    busAccess(1'b0, IRQ_REG_PENDING, 32'h0, rd); checkOutput("basic_pending", rd, 32'h1);
    busAccess(1'b0, IRQ_REG_CLAIM, 32'h0, rd);   checkOutput("basic_claim", rd, 32'h1);
    checkOutput("basic_irq_fall", {31'b0, o_IRQ}, 32'h0);
    busAccess(1'b0, IRQ_REG_PENDING, 32'h0, rd); checkOutput("basic_pending0", rd, 32'h0);
    busAccess(1'b0, IRQ_REG_CTRL, 32'h0, rd);    checkOutput("basic_ctrl1", rd, 32'h101);
    busAccess(1'b1, IRQ_REG_CLAIM, 32'h1, rd);
    busAccess(1'b0, IRQ_REG_CTRL, 32'h0, rd);    checkOutput("basic_ctrl0", rd, 32'h001);

    // Priority, bad completes, masking, GIE and a UART-style rx interrupt.
    vecs.push_back(mk(1, IRQ_REG_ENABLE,  32'hFF, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, IRQ_REG_PENDING, 0,      8'h06, 32'h06, 1, 2));
    vecs.push_back(mk(0, IRQ_REG_CLAIM,   0,      8'h06, 32'h2, 1, 3));
    vecs.push_back(mk(0, IRQ_REG_CLAIM,   0,      8'h06, 32'h3, 0, 0));
    vecs.push_back(mk(0, IRQ_REG_CLAIM,   0,      8'h06, 32'h0, 0, 0));
    vecs.push_back(mk(0, IRQ_REG_CTRL,    0,      8'h06, 32'h201, 0, 0));
    vecs.push_back(mk(1, IRQ_REG_CLAIM,   32'h2,  8'h06, 0, 1, 2));
    vecs.push_back(mk(0, IRQ_REG_CLAIM,   0,      8'h06, 32'h2, 0, 0));
    vecs.push_back(mk(1, IRQ_REG_CLAIM,   32'h0,  8'h06, 0, 0, 0));
    vecs.push_back(mk(1, IRQ_REG_CLAIM,   32'h9,  8'h06, 0, 0, 0));
    vecs.push_back(mk(1, IRQ_REG_CLAIM,   32'h1,  8'h06, 0, 0, 0));
    vecs.push_back(mk(0, IRQ_REG_CTRL,    0,      8'h06, 32'h201, 0, 0));
    vecs.push_back(mk(1, IRQ_REG_CLAIM,   32'h2,  8'h00, 0, 0, 0));
    vecs.push_back(mk(1, IRQ_REG_CLAIM,   32'h3,  8'h00, 0, 0, 0));
    vecs.push_back(mk(0, IRQ_REG_CTRL,    0,      8'h00, 32'h001, 0, 0));
    vecs.push_back(mk(1, IRQ_REG_ENABLE,  32'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, IRQ_REG_PENDING, 0,      8'h08, 32'h08, 0, 0));
    vecs.push_back(mk(0, IRQ_REG_CLAIM,   0,      8'h08, 32'h0, 0, 0));
    vecs.push_back(mk(1, IRQ_REG_ENABLE,  32'h08, 8'h08, 0, 1, 4));
    vecs.push_back(mk(0, IRQ_REG_CLAIM,   0,      8'h08, 32'h4, 0, 0));
    vecs.push_back(mk(1, IRQ_REG_CLAIM,   32'h4,  8'h00, 0, 0, 0));
    vecs.push_back(mk(0, IRQ_REG_ENABLE,  0,      8'h00, 32'h08, 0, 0));
    vecs.push_back(mk(1, IRQ_REG_CTRL,    32'h0,  8'h08, 0, 0, 4));
    vecs.push_back(mk(1, IRQ_REG_CTRL,    32'h1,  8'h08, 0, 1, 4));
    vecs.push_back(mk(0, IRQ_REG_CLAIM,   0,      8'h00, 32'h4, 0, 0));
    vecs.push_back(mk(1, IRQ_REG_CLAIM,   32'h4,  8'h00, 0, 0, 0));
    vecs.push_back(mk(1, IRQ_REG_ENABLE,  32'h01, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, IRQ_REG_CLAIM,   0,      8'h01, 32'h1, 0, 0));
    vecs.push_back(mk(1, IRQ_REG_CLAIM,   32'h1,  8'h00, 0, 0, 0));
    vecs.push_back(mk(0, IRQ_REG_PENDING, 0,      8'h00, 32'h0, 0, 0));
    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Claim and a new source on the same edge: the old winner is returned.
    busAccess(1'b1, IRQ_REG_ENABLE, 32'hFF, rd);
    i_SRC = 8'h01;
    repeat (3) @(posedge i_CLK);
    @(negedge i_CLK);
    i_SRC = 8'h05;
    i_CYC = 1'b1; i_STB = 1'b1; i_WE = 1'b0;
    i_ADDR = {28'h0, IRQ_REG_CLAIM, 2'b00};
    @(posedge i_CLK);
    #1;
    checkOutput("simul_ack", {31'b0, o_ACK}, 32'h1);
    checkOutput("simul_claim", o_DATA, 32'h1);
    i_CYC = 1'b0; i_STB = 1'b0;
    @(posedge i_CLK);
    #1;
    busAccess(1'b0, IRQ_REG_CLAIM, 32'h0, rd);   checkOutput("simul_next", rd, 32'h3);
    i_SRC = 8'h00;
    busAccess(1'b0, IRQ_REG_CTRL, 32'h0, rd);    checkOutput("simul_ctrl", rd, 32'h201);

    // Reset in the middle of a write: no ack and no side effect.
    @(negedge i_CLK);
    i_RST = 1'b1;
    i_CYC = 1'b1; i_STB = 1'b1; i_WE = 1'b1;
    i_ADDR = {28'h0, IRQ_REG_ENABLE, 2'b00};
    i_DATA = 32'hFF;
    @(posedge i_CLK);
    #1;
    checkOutput("rstmid_ack", {31'b0, o_ACK}, 32'h0);
    i_CYC = 1'b0; i_STB = 1'b0; i_WE = 1'b0;
    repeat (2) @(posedge i_CLK);
    @(negedge i_CLK);
    i_RST = 1'b0;
    busAccess(1'b0, IRQ_REG_ENABLE, 32'h0, rd); checkOutput("rstmid_enable", rd, 32'h0);
    busAccess(1'b0, IRQ_REG_CTRL, 32'h0, rd);   checkOutput("rstmid_ctrl", rd, 32'h0);
    mReset();

    // Randomized traffic against the model.
    for (int it = 0; it < 250; it++) begin
      src = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) src = 8'h00;
      i_SRC = src;
      repeat (3) @(posedge i_CLK);
      #1;
      mSettle(src);
      exp_id = mWinner();
      checkOutput("rnd_irq", {31'b0, o_IRQ}, {31'b0, m_gie && (exp_id != 0)});
      checkOutput("rnd_id", {27'b0, o_IRQ_ID}, 32'(exp_id));

      op = $urandom_range(0, 5);
      case (op)
        0, 1: begin
          busAccess(1'b0, IRQ_REG_CLAIM, 32'h0, rd);
          checkOutput("rnd_claim", rd, 32'(exp_id));
          if (exp_id != 0) begin
            m_pend[exp_id-1] = 1'b0;
            m_isvc[exp_id-1] = 1'b1;
          end
        end
        2: begin
          d = ($urandom_range(0, 2) != 0) ? 32'($urandom_range(1, N)) : 32'($urandom_range(0, 9));
          busAccess(1'b1, IRQ_REG_CLAIM, d, rd);
          if (d >= 1 && d <= N && m_isvc[d-1]) m_isvc[d-1] = 1'b0;
        end
        3: begin
          d = $urandom;
          busAccess(1'b1, IRQ_REG_ENABLE, d, rd);
          m_en = d[7:0];
        end
        4: begin
          d = $urandom;
          busAccess(1'b1, IRQ_REG_CTRL, d, rd);
          m_gie = d[0];
        end
        default: begin
          case ($urandom_range(0, 2))
            0:       begin busAccess(1'b0, IRQ_REG_PENDING, 32'h0, rd); checkOutput("rnd_pending", rd, mRead(IRQ_REG_PENDING)); end
            1:       begin busAccess(1'b0, IRQ_REG_ENABLE, 32'h0, rd);  checkOutput("rnd_enable", rd, mRead(IRQ_REG_ENABLE)); end
            default: begin busAccess(1'b0, IRQ_REG_CTRL, 32'h0, rd);    checkOutput("rnd_ctrl", rd, mRead(IRQ_REG_CTRL)); end
          endcase
        end
      endcase
      repeat (2) @(posedge i_CLK);
      #1;
      mSettle(src);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
